// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator driver: opcodes, FSM states,
// command payload and the divide-by-zero result code.
package calc_pkg;

    localparam int unsigned OPND_W = 8;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned RES_W  = 16;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        HOLD = 2'b10
    } state_e;

    localparam logic [RES_W-1:0] DIV0_RESULT = 16'hFFFF;

    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        op_e               op;
    } cmd_t;

    // A divide with a zero divisor never uses the calculator's answer.
    function automatic logic is_div0(input cmd_t c);
        return (c.op == OP_DIV) && (c.b == '0);
    endfunction

endpackage

// File: rtl/calc_cmd_fifo.sv
// Command queue: DEPTH entries of {a,b,op}, wrap-around pointers, registered
// full/empty flags. Pushes at full and pops at empty are ignored.
module calc_cmd_fifo
    import calc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t wdata,
    input  logic pop,
    output cmd_t rdata,
    output logic full,
    output logic empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/calc_driver.sv
// Queues calculator commands, drives them one at a time onto an external
// combinational calculator, and holds each captured result for a consumer.
module calc_driver
    import calc_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OPND_W-1:0] cmd_a,
    input  logic [OPND_W-1:0] cmd_b,
    input  logic [OP_W-1:0]   cmd_op,
    output logic [OPND_W-1:0] first_num,
    output logic [OPND_W-1:0] second_num,
    output logic [OP_W-1:0]   operation,
    input  logic [RES_W-1:0]  calc_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic              res_err
);

    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_e           state;
    cmd_t             drive;
    cmd_t             head;
    cmd_t             wdata;
    logic [CNT_W-1:0] settle_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    assign wdata = '{a: cmd_a, b: cmd_b, op: op_e'(cmd_op)};
    assign pop   = (state == IDLE) && !fifo_empty;

    calc_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .wdata (wdata),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cmd_ready  = !fifo_full;
    assign first_num  = drive.a;
    assign second_num = drive.b;
    assign operation  = drive.op;

    // The drive register only changes on a pop, so operands stay put through WAIT/HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            drive      <= '{a: '0, b: '0, op: OP_ADD};
            settle_cnt <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        drive      <= head;
                        settle_cnt <= '0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    settle_cnt <= settle_cnt + CNT_W'(1);
                    if (settle_cnt == CNT_W'(SETTLE - 1)) begin
                        if (is_div0(drive)) begin
                            res_data <= DIV0_RESULT;
                            res_err  <= 1'b1;
                        end else begin
                            res_data <= calc_out;
                            res_err  <= 1'b0;
                        end
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/calc_driver.md
CALC_DRIVER -- requirements
Module: calc_driver

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 Parameter SETTLE, default 1, clock edges between driving operands and capturing calc_out (>=1).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  FIFO not full; command accepted when cmd_valid&&cmd_ready at an edge.
REQ-007 cmd_a  input  8  first operand.
REQ-008 cmd_b  input  8  second operand.
REQ-009 cmd_op  input  2  opcode: 00 add, 01 sub, 10 mul, 11 div.
REQ-010 first_num  output  8  operand A driven to the attached combinational calculator.
REQ-011 second_num  output  8  operand B driven to the calculator.
REQ-012 operation  output  2  opcode driven to the calculator.
REQ-013 calc_out  input  16  calculator result.
REQ-014 res_valid  output  1  result held for consumer.
REQ-015 res_ready  input  1  consumer accepts; transfer when res_valid&&res_ready at an edge.
REQ-016 res_data  output  16  captured result.
REQ-017 res_err  output  1  result is a divide-by-zero (res_data = 16'hFFFF).

Function
REQ-018 Commands SHALL be served strictly in FIFO order; none dropped or duplicated.
REQ-019 cmd_ready SHALL be low exactly when FIFO holds DEPTH entries; a push at full is ignored.
REQ-020 Simultaneous push and pop at full SHALL be refused; simultaneous push and pop when partially filled SHALL keep the count unchanged.
REQ-021 FSM states: IDLE, WAIT, HOLD.
REQ-022 IDLE: FIFO non-empty -> pop head at the edge, register it onto first_num/second_num/operation, go WAIT with settle counter cleared; FIFO empty -> stay.
REQ-023 WAIT: counter increments each edge; on the SETTLE-th edge after the pop, capture calc_out into res_data, res_err=0, go HOLD.
REQ-024 Div-by-zero (op 11, b 0): in WAIT, on the same capture edge, res_data SHALL be 16'hFFFF and res_err=1, ignoring calc_out.
REQ-025 HOLD: res_valid=1; res_data/res_err stable until transfer; on transfer go IDLE.
REQ-026 first_num/second_num/operation SHALL stay constant from the pop until the next pop.
REQ-027 Latency: with SETTLE=1, push into an empty idle block at edge P -> pop at P+1 -> res_valid high after edge P+2.
REQ-028 Throughput: one result per SETTLE+2 cycles when res_ready is held high.
REQ-029 No arithmetic inside the block; res_data equals calc_out bit-for-bit (sub wraps modulo 2^16 as delivered).
REQ-030 res_valid SHALL never drop without a transfer, except on reset.

Reset
REQ-031 rst asserted at any time, including mid-WAIT or mid-HOLD, SHALL immediately force IDLE and empty the FIFO, discarding the in-flight command.
REQ-032 Reset values: cmd_ready=1, res_valid=0, res_data=0, res_err=0, first_num=0, second_num=0, operation=00, settle counter=0.
REQ-033 First push SHALL be accepted on the first edge after rst deasserts.

Structure
REQ-034 Shared package calc_pkg SHALL hold the opcode enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV), the FSM state enum and constant DIV0_RESULT=16'hFFFF.
REQ-035 One sub-module, calc_cmd_fifo (DEPTH entries of {a,b,op}, full/empty, wrap-around pointers), instantiated once.
REQ-036 The calculator itself is external; the bench attaches a combinational model.

Verification
REQ-037 Push (200,100,00) with res_ready=1 -> res_data=300, res_err=0, res_valid after edge P+2.
REQ-038 Push sub 200-100, mul 200*100, div 200/100 back-to-back -> res_data 100, 20000, 2 in order.
REQ-039 Push (5,0,11) -> res_data=16'hFFFF, res_err=1; then (6,3,11) -> 2, res_err=0.
REQ-040 res_ready=0, push DEPTH+2 commands -> cmd_ready low after 1+DEPTH accepted (one in HOLD); release res_ready -> all accepted results drain in order, none lost.
REQ-041 Push (100,200,01) -> res_data=16'hFF9C (wrap); check operand outputs stable through WAIT/HOLD.
REQ-042 Assert rst during WAIT with 3 queued -> res_valid=0, cmd_ready=1, no stale result after release; a new push returns its correct result.
